// File: rtl/mig_rw_tester.sv
// Write/read-back tester for the MIG 7-series app interface (ui_clk domain).
// Define MIG_RW_LOOP_EN to repeat passes forever; default build runs a single pass.
module mig_rw_tester #(
  parameter int          ADDR_W    = 28,
  parameter int          DATA_W    = 128,
  parameter int          BURST_NUM = 64,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_STEP = 8,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  init_calib_complete,
  input  logic                  app_rdy,
  input  logic                  app_wdf_rdy,
  input  logic [DATA_W-1:0]     app_rd_data,
  input  logic                  app_rd_data_valid,
  output logic [ADDR_W-1:0]     app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  output logic [DATA_W-1:0]     app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [DATA_W/8-1:0]   app_wdf_mask,
  output logic                  test_done,
  output logic                  test_err,
  output logic [15:0]           err_cnt,
  output logic [15:0]           pass_cnt
);

  localparam int                CNT_W   = 17;
  localparam int                LANES   = DATA_W / 16;
  localparam logic [CNT_W-1:0]  BURST   = CNT_W'(BURST_NUM);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);
  localparam logic [31:0]       TMO_MAX = 32'(TIMEOUT);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_CAL = 3'd1;
  localparam logic [2:0] S_WR       = 3'd2;
  localparam logic [2:0] S_RD       = 3'd3;
  localparam logic [2:0] S_RD_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]       state;
  logic [CNT_W-1:0] cmd_cnt;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [31:0]      tmo;
  logic [15:0]      wr_word;
  logic [15:0]      rd_word;
  logic             cmd_fire;
  logic             wd_fire;
  logic             rd_take;
  logic             rd_bad;

  // All app-side outputs decode from registered state, never from MIG inputs.
  assign app_en       = (state == S_WR || state == S_RD) && (cmd_cnt < BURST);
  assign app_cmd      = (state == S_RD) ? 3'b001 : 3'b000;
  assign app_wdf_wren = (state == S_WR) && (wd_cnt < BURST);
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;

  assign wr_word      = wd_cnt[15:0] + pass_cnt;
  assign rd_word      = rd_cnt[15:0] + pass_cnt;
  assign app_wdf_data = app_wdf_wren ? {LANES{wr_word}} : '0;

  assign cmd_fire = app_en & app_rdy;
  assign wd_fire  = app_wdf_wren & app_wdf_rdy;
  // Read data is accepted in RD as well as RD_WAIT so a strobe on a state change is kept.
  assign rd_take  = app_rd_data_valid && (state == S_RD || state == S_RD_WAIT) && (rd_cnt < BURST);
  assign rd_bad   = rd_take && (app_rd_data != {LANES{rd_word}});

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      app_addr  <= BASE;
      cmd_cnt   <= '0;
      wd_cnt    <= '0;
      rd_cnt    <= '0;
      tmo       <= '0;
      test_done <= 1'b0;
      test_err  <= 1'b0;
      err_cnt   <= '0;
      pass_cnt  <= '0;
    end else begin
      // NOTE: non-blocking updates here; later assignments in the case below
      // deliberately override the handshake updates above (last one wins).
      if (cmd_fire) begin
        cmd_cnt  <= cmd_cnt + CNT_W'(1);
        app_addr <= app_addr + STEP;
      end
      if (wd_fire) wd_cnt <= wd_cnt + CNT_W'(1);
      if (rd_take) rd_cnt <= rd_cnt + CNT_W'(1);
      if (rd_bad) begin
        test_err <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end

      case (state)
        S_IDLE:     state <= S_WAIT_CAL;
        S_WAIT_CAL: if (init_calib_complete) state <= S_WR;
        S_WR: begin
          if (cmd_cnt == BURST && wd_cnt == BURST) begin
            state    <= S_RD;
            app_addr <= BASE;
            cmd_cnt  <= '0;
          end
        end
        S_RD: begin
          tmo <= '0;
          if (cmd_cnt == BURST) state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (rd_cnt == BURST) begin
            state     <= S_DONE;
            test_done <= 1'b1;
            pass_cnt  <= pass_cnt + 16'd1;
          end else if (tmo == TMO_MAX) begin
            state     <= S_DONE;
            test_done <= 1'b1;
            test_err  <= 1'b1;
            pass_cnt  <= pass_cnt + 16'd1;
          end else if (app_rd_data_valid) begin
            tmo <= '0;
          end else begin
            tmo <= tmo + 32'd1;
          end
        end
        S_DONE: begin
`ifdef MIG_RW_LOOP_EN
          state     <= S_WR;
          test_done <= 1'b0;
          app_addr  <= BASE;
          cmd_cnt   <= '0;
          wd_cnt    <= '0;
          rd_cnt    <= '0;
          tmo       <= '0;
`else
          state <= S_DONE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mig_rw_tester.sv
// Self-checking bench for mig_rw_tester: behavioural MIG app model (memory + in-order
// read queue), table-driven scenarios, randomized stall/corruption runs and reset/loop sequences.
module tb_mig_rw_tester;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int BURST  = 4;
  localparam int STEP   = 8;
  localparam int TMO    = 256;

  logic                sysclk = 1'b0;
  logic                rst = 1'b1;
  logic                init_calib_complete = 1'b0;
  logic                app_rdy = 1'b0;
  logic                app_wdf_rdy = 1'b0;
  logic [DATA_W-1:0]   app_rd_data = '0;
  logic                app_rd_data_valid = 1'b0;
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                test_done;
  logic                test_err;
  logic [15:0]         err_cnt;
  logic [15:0]         pass_cnt;

  mig_rw_tester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_NUM(BURST),
    .BASE_ADDR(0), .ADDR_STEP(STEP), .TIMEOUT(TMO)
  ) dut (
    .sysclk(sysclk), .rst(rst), .init_calib_complete(init_calib_complete),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .test_done(test_done),
    .test_err(test_err), .err_cnt(err_cnt), .pass_cnt(pass_cnt)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int k, input int p);
    logic [15:0] v;
    v = 16'(k + p);
    return {(DATA_W/16){v}};
  endfunction

  // ---------------- app-side model ----------------
  typedef struct { logic [2:0] cmd; logic [ADDR_W-1:0] addr; } cmd_t;
  typedef struct { int due; logic [DATA_W-1:0] data; } rd_t;

  int          rdy_mode = 0;          // 0 always ready, 1 alternate, 2 random
  int          stall_start = 0;
  int          stall_len = 0;
  int          rd_lat = 3;
  logic [31:0] corrupt_mask = '0;
  int          return_n = BURST;
  int          calib_cycle = 20;
  int          calib_drop = -1;

  int                cyc;
  cmd_t              cmd_log[$];
  logic [DATA_W-1:0] data_log[$];
  logic [ADDR_W-1:0] wq[$];
  logic [DATA_W-1:0] dq[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  rd_t               rq[$];
  rd_t               rtmp;
  int                rd_issued, last_due, stall_viol, done_pulses;
  time               last_valid_t;
  logic              prev_en_stall, prev_wr_stall, prev_done;
  logic [ADDR_W-1:0] prev_addr;
  logic [2:0]        prev_cmd;
  logic [DATA_W-1:0] prev_wdata;
  logic [DATA_W-1:0] rdat;

  task automatic model_clear();
    cyc = 0; cmd_log.delete(); data_log.delete(); wq.delete(); dq.delete();
    mem.delete(); rq.delete(); rd_issued = 0; last_due = 0; stall_viol = 0;
    done_pulses = 0; prev_en_stall = 0; prev_wr_stall = 0; prev_done = 0;
    app_rdy = 0; app_wdf_rdy = 0; app_rd_data_valid = 0; init_calib_complete = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_clear();
      return;
    end
    // a request stalled last cycle must still be presented unchanged
    if (prev_en_stall && !(app_en && app_cmd == prev_cmd && app_addr == prev_addr)) stall_viol++;
    if (prev_wr_stall && !(app_wdf_wren && app_wdf_data == prev_wdata)) stall_viol++;
    init_calib_complete = (cyc >= calib_cycle) && !(calib_drop >= 0 && cyc >= calib_drop);
    case (rdy_mode)
      1:       app_rdy = (cyc % 2) == 1;
      2:       app_rdy = ($urandom % 3) != 0;
      default: app_rdy = 1'b1;
    endcase
    app_wdf_rdy = !(cyc >= stall_start && cyc < stall_start + stall_len);
    if (rdy_mode == 2) app_wdf_rdy = app_wdf_rdy && (($urandom % 3) != 0);
    if (app_wdf_wren && app_wdf_rdy) begin
      data_log.push_back(app_wdf_data);
      dq.push_back(app_wdf_data);
    end
    if (app_en && app_rdy) begin
      cmd_log.push_back('{cmd: app_cmd, addr: app_addr});
      if (app_cmd == 3'b000) wq.push_back(app_addr);
    end
    while (wq.size() > 0 && dq.size() > 0) mem[wq.pop_front()] = dq.pop_front();
    if (app_en && app_rdy && app_cmd == 3'b001) begin
      rdat = mem.exists(app_addr) ? mem[app_addr] : '0;
      if (rd_issued < 32 && corrupt_mask[rd_issued]) rdat = rdat ^ 128'h1;
      if (rd_issued < return_n) begin
        rtmp.due = (cyc + rd_lat > last_due) ? cyc + rd_lat : last_due + 1;
        rtmp.data = rdat;
        last_due = rtmp.due;
        rq.push_back(rtmp);
      end
      rd_issued++;
    end
    prev_en_stall = app_en && !app_rdy;
    prev_cmd = app_cmd;
    prev_addr = app_addr;
    prev_wr_stall = app_wdf_wren && !app_wdf_rdy;
    prev_wdata = app_wdf_data;
    app_rd_data_valid = 1'b0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      rtmp = rq.pop_front();
      app_rd_data = rtmp.data;
      app_rd_data_valid = 1'b1;
      last_valid_t = $time;
    end
    if (test_done && !prev_done) done_pulses++;
    prev_done = test_done;
    cyc++;
  endtask

  initial forever begin
    @(negedge sysclk);
    model_step();
  end

  // ---------------- sequencing helpers ----------------
  task automatic check_reset_outs(input string tag);
    check({tag, "_en_wren"}, {app_en, app_wdf_wren, app_wdf_end}, 3'b000);
    check({tag, "_addr_cmd"}, {app_addr, app_cmd}, {28'd0, 3'b000});
    check({tag, "_wdata"}, app_wdf_data, '0);
    check({tag, "_status"}, {test_done, test_err, err_cnt, pass_cnt}, '0);
  endtask

  task automatic do_reset(input bit chk);
    @(posedge sysclk); #2 rst = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    if (chk) begin
      check_reset_outs("reset");
      check("reset_mask", app_wdf_mask, '0);
    end
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge sysclk); #2;
      if (test_done) begin ok = 1; break; end
    end
  endtask

  // checks pass 0 traffic: 4 writes then 4 reads in address order, pattern data
  task automatic check_traffic(input string tag, input int ncmd, input int ndat);
    check({tag, "_ncmd"}, ncmd, 2 * BURST);
    check({tag, "_ndata"}, ndat, BURST);
    for (int j = 0; j < ncmd && j < 2 * BURST; j++)
      check($sformatf("%s_cmd%0d", tag, j), {cmd_log[j].cmd, cmd_log[j].addr},
            {(j < BURST) ? 3'b000 : 3'b001, 28'((j % BURST) * STEP)});
    for (int j = 0; j < ndat && j < BURST; j++)
      check($sformatf("%s_wdata%0d", tag, j), data_log[j], pat(j, 0));
    check({tag, "_stall_stable"}, stall_viol, 0);
  endtask

  typedef struct {
    string       name;
    int          rdy_mode;
    int          stall_start;
    int          stall_len;
    int          lat;
    logic [31:0] corrupt;
    int          ret_n;
    logic        exp_err;
    int          exp_err_cnt;
  } vec_t;

  task automatic run_vec(input vec_t v);
    bit ok;
    int ncmd, ndat;
    time td;
    rdy_mode = v.rdy_mode; stall_start = v.stall_start; stall_len = v.stall_len;
    rd_lat = v.lat; corrupt_mask = v.corrupt; return_n = v.ret_n;
    do_reset(1);
    wait_done(3000, ok);
    td = $time;
    check({v.name, "_done_seen"}, ok, 1'b1);
    ncmd = cmd_log.size(); ndat = data_log.size();
    check({v.name, "_err"}, test_err, v.exp_err);
    check({v.name, "_err_cnt"}, err_cnt, 16'(v.exp_err_cnt));
    check({v.name, "_pass_cnt"}, pass_cnt, 16'd1);
    check_traffic(v.name, ncmd, ndat);
    if (v.ret_n < BURST) begin
      int dc;
      dc = int'((td - last_valid_t) / 10);
      check({v.name, "_timeout_span"}, (dc >= TMO && dc <= TMO + 2), 1'b1);
    end
`ifndef MIG_RW_LOOP_EN
    repeat (5) @(posedge sysclk);
    #2;
    check({v.name, "_done_held"}, {test_done, app_en, app_wdf_wren}, 3'b100);
    check({v.name, "_pass_held"}, pass_cnt, 16'd1);
`endif
  endtask

  vec_t vecs[4];

  initial begin
    bit ok;
    model_clear();
    vecs[0] = '{"basic",   0, 0,  0, 3, 32'h0, 4, 1'b0, 0};
    vecs[1] = '{"stall",   1, 21, 5, 5, 32'h0, 4, 1'b0, 0};
    vecs[2] = '{"corrupt", 0, 0,  0, 3, 32'h4, 4, 1'b1, 1};
    vecs[3] = '{"short",   0, 0,  0, 3, 32'h0, 3, 1'b1, 0};
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // randomized: random ready patterns, latency, corruption, calib drop after rise
    for (int r = 0; r < 4; r++) begin
      vec_t v;
      v.name = $sformatf("rand%0d", r);
      v.rdy_mode = 2; v.stall_start = 0; v.stall_len = 0;
      v.lat = 1 + int'($urandom_range(0, 7));
      v.corrupt = 32'($urandom_range(0, 15));
      v.ret_n = BURST;
      v.exp_err_cnt = $countones(v.corrupt[3:0]);
      v.exp_err = (v.exp_err_cnt != 0);
      calib_cycle = 1 + int'($urandom_range(0, 30));
      calib_drop = calib_cycle + 3 + int'($urandom_range(0, 10));
      run_vec(v);
    end
    calib_cycle = 20; calib_drop = -1;

    // asynchronous reset in the middle of the write phase
    rdy_mode = 1; stall_start = 0; stall_len = 0; rd_lat = 3; corrupt_mask = '0; return_n = BURST;
    do_reset(0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge sysclk); #2;
      if (cmd_log.size() == 2) begin ok = 1; break; end
    end
    check("midwr_reached", ok, 1'b1);
    @(posedge sysclk); #3 rst = 1'b1;
    #1 check_reset_outs("midwr_async");
    repeat (3) @(posedge sysclk);
    #2 rst = 1'b0;
    wait_done(3000, ok);
    check("midwr_done_seen", ok, 1'b1);
    check_traffic("midwr", cmd_log.size(), data_log.size());
    check("midwr_status", {test_err, err_cnt, pass_cnt}, {1'b0, 16'd0, 16'd1});

`ifdef MIG_RW_LOOP_EN
    rdy_mode = 0; corrupt_mask = '0; return_n = 1000;
    do_reset(0);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge sysclk); #2;
      if (done_pulses == 3) begin ok = 1; break; end
    end
    check("loop_three_passes", ok, 1'b1);
    @(posedge sysclk); #2;
    check("loop_pass_cnt", pass_cnt, 16'd3);
    check("loop_status", {test_err, err_cnt}, 17'd0);
    check("loop_pass2_word0", data_log[BURST], {(DATA_W/16){16'h0001}});
    for (int j = 0; j < 3 * BURST && j < data_log.size(); j++)
      check($sformatf("loop_wdata%0d", j), data_log[j], pat(j % BURST, j / BURST));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
